// File: rtl/harvard_fetch.sv
// Instruction fetch stage: PC, instruction-memory read handshake, decode handoff, delayed redirects.
// Optional HARVARD_FETCH_ALIGN_CHECK_EN: a misaligned next PC halts the stage with fault=1.
module harvard_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic [31:0] instr_readdata,
  input  logic        instr_waitrequest,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        active,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        accept;
  logic [31:0] seq_pc;
  logic [31:0] raw_next_pc;
  logic [31:0] next_pc;
  logic        misaligned;
`ifdef HARVARD_FETCH_ALIGN_CHECK_EN
  logic        fault_q, fault_d;
`endif

  assign accept = (state_q == HOLD) && decode_ready;
  assign seq_pc = pend_valid_q ? pend_target_q : (pc_q + 32'd4);
  // A redirect arriving with the accept means the accepted word is the delay slot.
  assign raw_next_pc = redirect_valid ? redirect_target : seq_pc;

`ifdef HARVARD_FETCH_ALIGN_CHECK_EN
  assign misaligned = (raw_next_pc[1:0] != 2'b00);
  assign next_pc    = raw_next_pc;
`else
  assign misaligned = 1'b0;
  assign next_pc    = raw_next_pc & ~32'h3;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    fetch_valid_d = fetch_valid_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
`ifdef HARVARD_FETCH_ALIGN_CHECK_EN
    fault_d       = fault_q;
`endif

    // Redirect not coinciding with an accept is parked until the delay slot is taken.
    if ((state_q != HALT) && redirect_valid && !accept) begin
      pend_valid_d  = 1'b1;
      pend_target_d = redirect_target;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (!instr_waitrequest) begin
          instr_d       = instr_readdata;
          pc_out_d      = pc_q;
          fetch_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (decode_ready) begin
          fetch_valid_d = 1'b0;
          pend_valid_d  = 1'b0;
          pc_d          = next_pc;
          if (misaligned) begin
`ifdef HARVARD_FETCH_ALIGN_CHECK_EN
            fault_d = 1'b1;
`endif
            state_d = HALT;
          end else if (next_pc == 32'd0) begin
            state_d = HALT;
          end else begin
            state_d = REQ;
          end
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_VECTOR;
      instr_q       <= 32'd0;
      pc_out_q      <= 32'd0;
      fetch_valid_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      fetch_valid_q <= fetch_valid_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

`ifdef HARVARD_FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign instr_address = pc_q;
  assign instr_read    = (state_q == REQ);
  assign instruction   = instr_q;
  assign pc_out        = pc_out_q;
  assign fetch_valid   = fetch_valid_q;
  assign active        = (state_q != HALT);

endmodule

// File: tb/tb_harvard_fetch.sv
// Directed bench for harvard_fetch; memory returns the bitwise inverse of the address.
module tb_harvard_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic        decode_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        active;
  logic        fault;

  int compared   = 0;
  int mismatched = 0;

  harvard_fetch dut (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_read(instr_read),
    .instr_readdata(instr_readdata), .instr_waitrequest(instr_waitrequest),
    .instruction(instruction), .pc_out(pc_out), .fetch_valid(fetch_valid),
    .decode_ready(decode_ready), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .active(active), .fault(fault)
  );

  always #5 clk = ~clk;
  assign instr_readdata = ~instr_address;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks a REQ cycle at the given address.
  task automatic check_req(input string tag, input logic [31:0] addr);
    check({tag, "_read"}, {31'd0, instr_read}, 32'd1);
    check({tag, "_addr"}, instr_address, addr);
    check({tag, "_fv"}, {31'd0, fetch_valid}, 32'd0);
    $display("REQ  %s addr=%h read=%b", tag, instr_address, instr_read);
  endtask

  // Checks a HOLD cycle presenting the word fetched from addr.
  task automatic check_hold(input string tag, input logic [31:0] addr);
    check({tag, "_fv"}, {31'd0, fetch_valid}, 32'd1);
    check({tag, "_pc"}, pc_out, addr);
    check({tag, "_ins"}, instruction, ~addr);
    check({tag, "_read"}, {31'd0, instr_read}, 32'd0);
    $display("HOLD %s pc_out=%h instr=%h", tag, pc_out, instruction);
  endtask

  initial begin
    reset = 1'b1; instr_waitrequest = 1'b0; decode_ready = 1'b1;
    redirect_valid = 1'b0; redirect_target = 32'd0;
    #1;
    tick(); tick();
    check("rst_addr", instr_address, 32'hBFC00000);
    check("rst_read", {31'd0, instr_read}, 32'd0);
    check("rst_ins", instruction, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_active", {31'd0, active}, 32'd1);
    check("rst_fault", {31'd0, fault}, 32'd0);
    $display("RESET addr=%h active=%b", instr_address, active);

    // Zero-wait streaming
    reset = 1'b0;
    tick(); check_req("s0", 32'hBFC00000);
    tick(); check_hold("s0", 32'hBFC00000);
    tick(); check_req("s1", 32'hBFC00004);

    // Wait-request held for 3 cycles on BFC00004
    instr_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); check_req("wait", 32'hBFC00004);
    end
    instr_waitrequest = 1'b0;
    tick(); check_hold("s1", 32'hBFC00004);

    // Decode stalls for 4 cycles
    decode_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_hold("stall", 32'hBFC00004);
    end
    decode_ready = 1'b1;
    tick(); check_req("s2", 32'hBFC00008);
    tick(); check_hold("s2", 32'hBFC00008);
    tick(); check_req("s3", 32'hBFC0000C);
    tick(); check_hold("s3", 32'hBFC0000C);
    tick(); check_req("s4", 32'hBFC00010);
    tick(); check_hold("br", 32'hBFC00010);
    tick(); check_req("ds", 32'hBFC00014);

    // Redirect after the branch was accepted: delay slot then target
    redirect_valid = 1'b1; redirect_target = 32'h00001000;
    tick(); redirect_valid = 1'b0;
    check_hold("ds", 32'hBFC00014);
    tick(); check_req("tgt", 32'h00001000);
    tick(); check_hold("tgt", 32'h00001000);

    // Redirect coincident with accept of the delay slot
    tick(); check_req("ds2", 32'h00001004);
    tick(); check_hold("ds2", 32'h00001004);
    redirect_valid = 1'b1; redirect_target = 32'h00002000;
    tick(); redirect_valid = 1'b0;
    check_req("tgt2", 32'h00002000);
    tick(); check_hold("tgt2", 32'h00002000);

    // Two redirects pending: later wins
    tick(); check_req("ds3", 32'h00002004);
    redirect_valid = 1'b1; redirect_target = 32'h00003000;
    tick(); check_hold("ds3", 32'h00002004);
    decode_ready = 1'b0; redirect_target = 32'h00004000;
    tick(); redirect_valid = 1'b0; decode_ready = 1'b1;
    check_hold("ds3b", 32'h00002004);
    tick(); check_req("tgt3", 32'h00004000);
    tick(); check_hold("tgt3", 32'h00004000);

    // Redirect to 0: delay slot delivered, then halt
    tick(); check_req("ds4", 32'h00004004);
    redirect_valid = 1'b1; redirect_target = 32'h00000000;
    tick(); redirect_valid = 1'b0;
    check_hold("ds4", 32'h00004004);
    tick();
    check("halt_active", {31'd0, active}, 32'd0);
    check("halt_fv", {31'd0, fetch_valid}, 32'd0);
    $display("HALT active=%b read=%b", active, instr_read);
    redirect_valid = 1'b1; redirect_target = 32'h00005000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("halt_read", {31'd0, instr_read}, 32'd0);
      check("halt_act2", {31'd0, active}, 32'd0);
    end
    redirect_valid = 1'b0;

    // Reset restarts at the reset vector
    reset = 1'b1;
    tick();
    check("rst2_active", {31'd0, active}, 32'd1);
    check("rst2_addr", instr_address, 32'hBFC00000);
    reset = 1'b0;
    tick(); check_req("r0", 32'hBFC00000);
    tick(); check_hold("r0", 32'hBFC00000);

    // Misaligned redirect coincident with accept of BFC00000
    redirect_valid = 1'b1; redirect_target = 32'h00001002;
    tick(); redirect_valid = 1'b0;
`ifdef HARVARD_FETCH_ALIGN_CHECK_EN
    check("mis_fault", {31'd0, fault}, 32'd1);
    check("mis_active", {31'd0, active}, 32'd0);
    check("mis_read", {31'd0, instr_read}, 32'd0);
    $display("MISALIGN fault=%b active=%b", fault, active);
`else
    check_req("mis", 32'h00001000);
    check("mis_fault", {31'd0, fault}, 32'd0);
    tick(); check_hold("mis", 32'h00001000);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/harvard_fetch.md
# harvard_fetch

Instruction fetch stage of the Harvard MIPS core; sits directly upstream of `harvard_decode`. Holds the program counter and issues reads to the instruction memory port with a wait-request handshake. Hands each fetched word plus its PC to decode over a valid/ready handshake. Applies branch/jump redirects after the architectural delay slot and halts the core when the PC reaches address 0.

## Interface
- `RESET_VECTOR`, 32'hBFC00000, PC loaded on reset.
- `clk`  in  1  single core clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_address`  out  32  word address presented to instruction memory; equals PC.
- `instr_read`  out  1  read request; high only in state REQ.
- `instr_readdata`  in  32  read data; valid in any REQ cycle with `instr_waitrequest`=0.
- `instr_waitrequest`  in  1  memory stall; request must be held while high.
- `instruction`  out  32  registered instruction word to decode.
- `pc_out`  out  32  PC of `instruction`.
- `fetch_valid`  out  1  `instruction`/`pc_out` valid for decode.
- `decode_ready`  in  1  decode accepts the word this cycle when `fetch_valid`=1.
- `redirect_valid`  in  1  one-cycle pulse from execute: branch/jump taken.
- `redirect_target`  in  32  target PC qualified by `redirect_valid`.
- `active`  out  1  high while running; low once halted.
- `fault`  out  1  misaligned-target fault (see Configuration).

## Operation
- States: IDLE, REQ, HOLD, HALT. Reset forces IDLE.
- IDLE: one cycle, no request; then REQ.
- REQ: `instr_read`=1, `instr_address`=PC. While `instr_waitrequest`=1 stay, address stable. When 0: latch `instr_readdata`→`instruction`, PC→`pc_out`, set `fetch_valid`, go HOLD.
- HOLD: `fetch_valid`=1, no request. On `decode_ready`=1 (accept): clear `fetch_valid`; PC ← next PC; go REQ, or HALT if next PC = 0.
- Next PC: `pend_target` if `pend_valid`, else PC+4 (modulo 2^32). Accept clears `pend_valid`.
- Redirect: `redirect_valid`=1 sets `pend_valid`, `pend_target`←`redirect_target`. The branch itself was accepted earlier; the next accepted word is the delay slot, and the PC after it is the target.
- Redirect in the same cycle as an accept: the word being accepted is the delay slot; next PC = `redirect_target` directly, `pend_valid` stays 0.
- Second redirect while `pend_valid`=1: overwrites `pend_target` (later wins).
- HALT: `active`=0, `instr_read`=0, `fetch_valid`=0; ignores all inputs until reset. Delay-slot word before halt is still delivered.
- Reset mid-transaction: abandons outstanding read, drops pending redirect, returns to IDLE.

## Timing
- Reset values: `instr_address`=RESET_VECTOR, `instr_read`=0, `instruction`=0, `pc_out`=0, `fetch_valid`=0, `active`=1, `fault`=0, `pend_valid`=0.
- Zero-wait memory: REQ (1) + HOLD (≥1) → peak one instruction per 2 cycles.
- `fetch_valid` rises the cycle after the read completes; `instruction`/`pc_out` stable throughout HOLD.
- Each wait-request cycle adds one cycle of latency; `decode_ready` low extends HOLD.
- `active` falls the cycle after the accept whose next PC is 0.

## Configuration
- `HARVARD_FETCH_ALIGN_CHECK_EN` defined: a next PC with bits [1:0]≠0 sends the FSM to HALT with `fault`=1 and `active`=0; no read is issued to that address.
- Undefined: bits [1:0] of next PC forced to 0, `fault` tied 0.

## Test plan
- Reset release, zero-wait memory, `decode_ready`=1: reads at BFC00000, BFC00004, BFC00008; `fetch_valid` pulses every 2nd cycle with matching `pc_out`.
- `instr_waitrequest` high 3 cycles on BFC00004: address held stable, `instr_read` held, `fetch_valid` delayed 3 cycles, data captured only on wait low.
- `decode_ready` low 4 cycles in HOLD: `instruction`/`pc_out` unchanged, no new read issued.
- Redirect to 0x00001000 after branch at BFC00010 accepted: BFC00014 (delay slot) delivered, then 0x00001000; redirect coincident with accept of BFC00014 gives same sequence.
- Redirect to 0: delay slot delivered, then `active`=0, no further `instr_read`; reset restarts at BFC00000.
- With `HARVARD_FETCH_ALIGN_CHECK_EN`, redirect to 0x00001002: delay slot delivered, then `fault`=1, `active`=0; without it fetch proceeds at 0x00001000.
